// File: rtl/cam_defs.sv
// Shared CAM definitions: FSM state encodings used by both the writer and the
// search-side CAM, plus the decimal digit helper for the address display.
package cam_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } cam_state_t;

    // Decimal digit of value at the given place (1 = units, 10 = tens, ...).
    function automatic logic [3:0] dec_digit(input int unsigned value, input int unsigned place);
        return 4'((value / place) % 32'd10);
    endfunction

endpackage

// File: rtl/cam_writer_bcd.sv
// BCD digit to seven-segment decoder, segments {g,f,e,d,c,b,a}, active high.
module cam_writer_bcd (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        unique case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/cam_writer.sv
// CAM insert/delete engine: linear scan for a duplicate or the lowest free
// entry, then write; combinational read-back port and seven-segment display.
module cam_writer
    import cam_defs::*;
#(
    parameter int dataSize    = 5,
    parameter int addressSize = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   writeReq,
    input  logic [dataSize-1:0]    writeData,
    input  logic                   delReq,
    input  logic [addressSize-1:0] delAddr,
    input  logic [addressSize-1:0] rdAddr,
    output logic [dataSize-1:0]    rdData,
    output logic                   rdValid,
    output logic                   busy,
    output logic                   done,
    output logic                   dup,
    output logic                   full,
    output logic [addressSize-1:0] address_out,
    output logic [6:0]             dispU,
    output logic [6:0]             dispT
);

    localparam int DEPTH = 2 ** addressSize;
    localparam logic [addressSize-1:0] LAST = {addressSize{1'b1}};

    cam_state_t             state, state_next;
    logic [addressSize-1:0] ptr;
    logic [addressSize-1:0] free_addr;
    logic                   free_found;
    logic [dataSize-1:0]    data_q;
    logic [DEPTH-1:0]       valid;
    logic [dataSize-1:0]    mem [DEPTH];

    logic hit, is_last, can_write;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        hit        = valid[ptr] && (mem[ptr] == data_q);
        is_last    = (ptr == LAST);
        // The last entry itself may be the first free one, recorded on this same edge.
        can_write  = free_found || !valid[ptr];
        state_next = state;
        unique case (state)
            ST_IDLE:  if (writeReq) state_next = ST_SCAN;
            ST_SCAN: begin
                if (hit)          state_next = ST_DONE;
                else if (is_last) state_next = can_write ? ST_WRITE : ST_DONE;
            end
            ST_WRITE: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            free_addr   <= '0;
            free_found  <= 1'b0;
            dup         <= 1'b0;
            full        <= 1'b0;
            address_out <= '0;
            valid       <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                ST_IDLE: begin
                    if (writeReq) begin
                        ptr        <= '0;
                        dup        <= 1'b0;
                        full       <= 1'b0;
                        free_found <= 1'b0;
                    end else if (delReq) begin
                        valid[delAddr] <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (hit) begin
                        dup         <= 1'b1;
                        address_out <= ptr;
                    end else begin
                        if (!valid[ptr] && !free_found) begin
                            free_addr  <= ptr;
                            free_found <= 1'b1;
                        end
                        if (!is_last)
                            ptr <= ptr + 1'b1;
                        else if (!can_write) begin
                            full        <= 1'b1;
                            address_out <= '0;
                        end
                    end
                end
                ST_WRITE: begin
                    valid[free_addr] <= 1'b1;
                    address_out      <= free_addr;
                end
                ST_DONE: ;
                default: ;
            endcase
        end
    end

    // NOTE: the data array and latched value carry no reset; valid bits alone
    // decide whether an entry exists, which keeps the storage a plain RAM.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && writeReq)
            data_q <= writeData;
        if (rst && state == ST_WRITE)
            mem[free_addr] <= data_q;
    end

    assign rdData  = mem[rdAddr];
    assign rdValid = valid[rdAddr];
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);

    logic [3:0] digit_u, digit_t;
    assign digit_u = dec_digit(32'(address_out), 32'd1);
    assign digit_t = dec_digit(32'(address_out), 32'd10);

    cam_writer_bcd u_bcd_units (.digit(digit_u), .seg(dispU));
    cam_writer_bcd u_bcd_tens  (.digit(digit_t), .seg(dispT));

endmodule

// File: tb/tb_cam_writer.sv
// Directed bench for cam_writer at depth 8: insert, duplicate, full, delete,
// write/delete collision and reset abort in mid-scan.
module tb_cam_writer;

    localparam int DW = 5;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          writeReq = 1'b0;
    logic [DW-1:0] writeData = '0;
    logic          delReq = 1'b0;
    logic [AW-1:0] delAddr = '0;
    logic [AW-1:0] rdAddr = '0;
    logic [DW-1:0] rdData;
    logic          rdValid, busy, done, dup, full;
    logic [AW-1:0] address_out;
    logic [6:0]    dispU, dispT;

    int checks = 0;
    int errors = 0;

    cam_writer #(.dataSize(DW), .addressSize(AW)) dut (
        .clk(clk), .rst(rst),
        .writeReq(writeReq), .writeData(writeData),
        .delReq(delReq), .delAddr(delAddr),
        .rdAddr(rdAddr), .rdData(rdData), .rdValid(rdValid),
        .busy(busy), .done(done), .dup(dup), .full(full),
        .address_out(address_out), .dispU(dispU), .dispT(dispT)
    );

    always #5 clk = ~clk;

    // Insert one value; lat counts the accept cycle as 1 and stops on done.
    task automatic do_insert(input logic [DW-1:0] value, output int lat);
        @(negedge clk);
        while (busy) @(negedge clk);
        writeReq  = 1'b1;
        writeData = value;
        @(posedge clk); #1;
        writeReq = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_delete(input logic [AW-1:0] addr);
        @(negedge clk);
        while (busy) @(negedge clk);
        delReq  = 1'b1;
        delAddr = addr;
        @(posedge clk); #1;
        delReq = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL delete_single_cycle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, dup, full} !== 4'b0000 || address_out !== 3'd0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b dup=%b full=%b addr=%0d, want all 0",
                     busy, done, dup, full, address_out);
        end
        checks++;
        if (dispU !== 7'h3F || dispT !== 7'h3F) begin
            errors++;
            $display("FAIL reset_display: dispU=%h dispT=%h, want 3f 3f", dispU, dispT);
        end
        for (int a = 0; a < 8; a++) begin
            rdAddr = AW'(a); #1;
            checks++;
            if (rdValid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid[%0d]: got %b, want 0", a, rdValid);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_first_insert();
        int lat;
        do_insert(5'd5, lat);
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL first_insert_latency: got %0d, want 10", lat);
        end
        checks++;
        if (address_out !== 3'd0 || dup !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL first_insert_result: addr=%0d dup=%b full=%b, want 0 0 0", address_out, dup, full);
        end
        rdAddr = 3'd0; #1;
        checks++;
        if (rdValid !== 1'b1 || rdData !== 5'd5) begin
            errors++;
            $display("FAIL first_insert_store: valid=%b data=%0d, want 1 5", rdValid, rdData);
        end
    endtask

    task automatic test_duplicate();
        int lat;
        do_insert(5'd6, lat);
        checks++;
        if (lat != 10 || address_out !== 3'd1 || dup !== 1'b0) begin
            errors++;
            $display("FAIL second_insert: lat=%0d addr=%0d dup=%b, want 10 1 0", lat, address_out, dup);
        end
        do_insert(5'd5, lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL dup_latency: got %0d, want 2", lat);
        end
        checks++;
        if (dup !== 1'b1 || full !== 1'b0 || address_out !== 3'd0) begin
            errors++;
            $display("FAIL dup_result: dup=%b full=%b addr=%0d, want 1 0 0", dup, full, address_out);
        end
        rdAddr = 3'd2; #1;
        checks++;
        if (rdValid !== 1'b0) begin
            errors++;
            $display("FAIL dup_no_write: valid[2]=%b, want 0", rdValid);
        end
    endtask

    task automatic test_full();
        int lat;
        // Addresses 2..7 receive 20..25.
        for (int i = 0; i < 6; i++) begin
            do_insert(DW'(20 + i), lat);
            checks++;
            if (address_out !== AW'(2 + i) || lat != 10) begin
                errors++;
                $display("FAIL fill_addr[%0d]: addr=%0d lat=%0d, want %0d 10", i, address_out, lat, 2 + i);
            end
        end
        checks++;
        if (dispU !== 7'h07 || dispT !== 7'h3F) begin
            errors++;
            $display("FAIL display_7: dispU=%h dispT=%h, want 07 3f", dispU, dispT);
        end
        do_insert(5'd9, lat);
        checks++;
        if (full !== 1'b1 || dup !== 1'b0 || address_out !== 3'd0 || lat != 9) begin
            errors++;
            $display("FAIL full_result: full=%b dup=%b addr=%0d lat=%0d, want 1 0 0 9",
                     full, dup, address_out, lat);
        end
        for (int a = 0; a < 8; a++) begin
            rdAddr = AW'(a); #1;
            checks++;
            if (rdValid !== 1'b1) begin
                errors++;
                $display("FAIL full_valid[%0d]: got %b, want 1", a, rdValid);
            end
        end
    endtask

    task automatic test_delete_reuse();
        int lat;
        do_delete(3'd3);
        rdAddr = 3'd3; #1;
        checks++;
        if (rdValid !== 1'b0) begin
            errors++;
            $display("FAIL delete_clears: valid[3]=%b, want 0", rdValid);
        end
        do_insert(5'd9, lat);
        checks++;
        if (address_out !== 3'd3 || full !== 1'b0 || lat != 10) begin
            errors++;
            $display("FAIL reuse_result: addr=%0d full=%b lat=%0d, want 3 0 10", address_out, full, lat);
        end
        rdAddr = 3'd3; #1;
        checks++;
        if (rdValid !== 1'b1 || rdData !== 5'd9 || dispU !== 7'h4F) begin
            errors++;
            $display("FAIL reuse_store: valid=%b data=%0d dispU=%h, want 1 9 4f", rdValid, rdData, dispU);
        end
    endtask

    task automatic test_write_delete_collision();
        int lat;
        do_delete(3'd6);
        @(negedge clk);
        while (busy) @(negedge clk);
        writeReq = 1'b1; writeData = 5'd17;
        delReq   = 1'b1; delAddr   = 3'd4;
        @(posedge clk); #1;
        writeReq = 1'b0; delReq = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (address_out !== 3'd6 || lat != 10 || dispU !== 7'h7D) begin
            errors++;
            $display("FAIL collision_insert: addr=%0d lat=%0d dispU=%h, want 6 10 7d", address_out, lat, dispU);
        end
        rdAddr = 3'd4; #1;
        checks++;
        if (rdValid !== 1'b1 || rdData !== 5'd22) begin
            errors++;
            $display("FAIL collision_del_dropped: valid=%b data=%0d, want 1 22", rdValid, rdData);
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        int done_seen = 0;
        @(negedge clk);
        while (busy) @(negedge clk);
        writeReq = 1'b1; writeData = 5'd30;
        @(posedge clk); #1;                      // scan cycle 1
        writeReq = 1'b0;
        delReq = 1'b1; delAddr = 3'd0;           // must be ignored while busy
        @(posedge clk); #1;                      // scan cycle 2
        delReq = 1'b0;
        done_seen += int'(done);
        rdAddr = 3'd0; #1;
        checks++;
        if (rdValid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_ignores_delete: valid[0]=%b busy=%b, want 1 1", rdValid, busy);
        end
        @(posedge clk); #1;                      // scan cycle 3
        done_seen += int'(done);
        @(posedge clk); #1;                      // scan cycle 4
        done_seen += int'(done);
        rst = 1'b0;
        @(posedge clk); #1;
        done_seen += int'(done);
        checks++;
        if (busy !== 1'b0 || done_seen != 0 || address_out !== 3'd0 || dup !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done_pulses=%0d addr=%0d dup=%b full=%b, want 0 0 0 0 0",
                     busy, done_seen, address_out, dup, full);
        end
        for (int a = 0; a < 8; a++) begin
            rdAddr = AW'(a); #1;
            checks++;
            if (rdValid !== 1'b0) begin
                errors++;
                $display("FAIL abort_valid[%0d]: got %b, want 0", a, rdValid);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        do_insert(5'd3, lat);
        checks++;
        if (address_out !== 3'd0 || lat != 10 || dup !== 1'b0) begin
            errors++;
            $display("FAIL post_abort_insert: addr=%0d lat=%0d dup=%b, want 0 10 0", address_out, lat, dup);
        end
    endtask

    initial begin
        test_reset();
        test_first_insert();
        test_duplicate();
        test_full();
        test_delete_reuse();
        test_write_delete_collision();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
